hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline hazard sequencer that sits beside the forwarding unit in the read/execute stages.
- Forwarding covers ALU results. Loads return their data several cycles after issue, so this block tracks outstanding load destinations in a scoreboard.
- It stalls the read stage until the dependent operand reaches writeback, where the forwarding path picks it up.
- It also sequences pipeline flushes on taken branches and keeps stall statistics and error flags.

Parameters:
- GPR_SIZE, 3, register address width; NUM_REGS = 2**GPR_SIZE.
- FLUSH_CYCLES, 2, cycles the FLUSH state holds after the branch cycle (1..15).
- MAX_STALL, 64, consecutive stall cycles that set stall_timeout.
- CNT_W, 16, width of stall_count.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  read stage holds a valid instruction.
- issue_address0  in  GPR_SIZE  operand 0 source register.
- issue_uses0  in  1  operand 0 is actually read.
- issue_address1  in  GPR_SIZE  operand 1 source register.
- issue_uses1  in  1  operand 1 is actually read.
- issue_writes  in  1  instruction writes a destination register.
- issue_destination  in  GPR_SIZE  destination register.
- issue_is_load  in  1  instruction is a load.
- load_done  in  1  load data delivered to writeback this cycle.
- load_destination  in  GPR_SIZE  register of the completing load.
- branch_taken  in  1  execute stage resolved a taken branch this cycle.
- stall_fetch  out  1  hold the fetch stage.
- stall_read  out  1  hold the read stage.
- bubble_exec  out  1  inject a NOP into execute.
- flush_fetch  out  1  kill the fetch stage contents.
- flush_read  out  1  kill the read stage contents.
- issue_fire  out  1  read-stage instruction advances this cycle.
- pending_mask  out  NUM_REGS  scoreboard bits, bit i = load to register i outstanding.
- stall_count  out  CNT_W  saturating count of stall cycles.
- stall_timeout  out  1  sticky: a stall run reached MAX_STALL.
- scoreboard_error  out  1  sticky: load_done arrived for a non-pending register.

Behaviour:
- Reset (async, rst_n=0):
  - pending_mask=0, state=RUN, flush counter=0, stall run counter=0, stall_count=0, both sticky flags=0.
  - All combinational outputs forced 0 while rst_n=0.
  - Reset mid-operation discards outstanding loads; no recovery.
- hazard (combinational, registered pending bits only, no same-cycle bypass from load_done):
  - hazard = issue_valid & ((issue_uses0 & pending[issue_address0]) | (issue_uses1 & pending[issue_address1]) | (issue_writes & pending[issue_destination])).
  - The last term is the WAW check; it keeps the scoreboard to one bit per register.
- FSM states: RUN, FLUSH.
  - RUN: branch_taken -> FLUSH and load flush counter with FLUSH_CYCLES. branch_taken has priority over hazard.
  - FLUSH: counter decrements each cycle; at 1 -> RUN. A branch_taken arriving in FLUSH reloads the counter.
- Outputs:
  - flush_fetch = flush_read = branch_taken | (state==FLUSH).
  - stall_read = stall_fetch = bubble_exec = (state==RUN) & ~branch_taken & hazard.
  - issue_fire = (state==RUN) & ~branch_taken & issue_valid & ~hazard.
- Scoreboard update at clock edge:
  - issue_fire & issue_is_load & issue_writes sets pending[issue_destination].
  - load_done clears pending[load_destination].
  - Set and clear to the same register cannot coincide: the WAW stall prevents it. If it occurs anyway, set wins.
  - load_done with pending[load_destination]=0 sets scoreboard_error and changes no bits.
  - Flushes never clear pending bits; loads issued before a branch are older and still complete.
- Stall statistics:
  - stall_count increments every cycle stall_read=1 and saturates at all-ones.
  - The stall run counter increments while stall_read=1 and clears when stall_read=0.
  - Reaching MAX_STALL sets stall_timeout, which stays set until reset.
- Latency:
  - Hazard detection and flush assertion are same-cycle (combinational).
  - Scoreboard changes are visible to hazard one cycle after the edge.
  - A dependent instruction therefore issues the cycle after load_done.

Test Plan:
- Load r3 issues (issue_fire, is_load, dest=3) -> pending_mask=0x08 next cycle. Next instruction reads r3 -> stall_read=bubble_exec=1. load_done dest=3 at cycle k -> stall deasserts and issue_fire=1 at cycle k+1.
- Load r2 pending; an instruction reads r5 with issue_uses1=0 and address1=2 -> no stall, issue_fire=1, pending unchanged.
- branch_taken during a hazard stall -> stall_read=0, flush_*=1 for 1+FLUSH_CYCLES=3 cycles, then RUN. pending_mask still holds r3.
- Second branch_taken in FLUSH cycle 1 -> flush extends to 2 more cycles after that branch. issue_fire=0 throughout.
- load_done for r6 with pending_mask=0 -> scoreboard_error=1 sticky, mask unchanged. A hazard held 64 cycles -> stall_timeout=1 and stall_count=64.
- rst_n pulsed low mid-stall with r1 pending -> outputs 0 immediately. After release pending_mask=0, stall_count=0, and the previously blocked read of r1 issues.

Source files
------------

// File: rtl/hazard_controller.sv
// hazard_controller
//
// Read/execute-stage hazard sequencer. It tracks outstanding load destinations
// in a one-bit-per-register scoreboard and stalls the read stage while an
// instruction depends on (or would overwrite) a register whose load has not
// yet reached writeback. It also sequences fetch/read flushes after a taken
// branch and keeps stall statistics plus sticky error flags.
//
// Handshake: the read stage offers an instruction with issue_valid; the
// instruction is consumed on a rising edge only when issue_fire=1. While
// stall_read=1 the read stage must hold the instruction and its fields stable.
// load_done is a single-cycle strobe with no back-pressure.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   issue_*                     read-stage instruction description
//   load_done/load_destination  load writeback strobe and its register
//   branch_taken                execute stage resolved a taken branch
//   stall_fetch/stall_read      hold fetch/read stages
//   bubble_exec                 inject a NOP into execute
//   flush_fetch/flush_read      kill fetch/read stage contents
//   issue_fire                  read-stage instruction advances this cycle
//   pending_mask                scoreboard, bit i = load to register i in flight
//   stall_count                 saturating count of stall cycles
//   stall_timeout               sticky: a stall run reached MAX_STALL cycles
//   scoreboard_error            sticky: load_done for a non-pending register
module hazard_controller #(
  parameter int GPR_SIZE     = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_STALL    = 64,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic [GPR_SIZE-1:0]      issue_address0,
  input  logic                     issue_uses0,
  input  logic [GPR_SIZE-1:0]      issue_address1,
  input  logic                     issue_uses1,
  input  logic                     issue_writes,
  input  logic [GPR_SIZE-1:0]      issue_destination,
  input  logic                     issue_is_load,
  input  logic                     load_done,
  input  logic [GPR_SIZE-1:0]      load_destination,
  input  logic                     branch_taken,
  output logic                     stall_fetch,
  output logic                     stall_read,
  output logic                     bubble_exec,
  output logic                     flush_fetch,
  output logic                     flush_read,
  output logic                     issue_fire,
  output logic [(2**GPR_SIZE)-1:0] pending_mask,
  output logic [CNT_W-1:0]         stall_count,
  output logic                     stall_timeout,
  output logic                     scoreboard_error
);

  localparam int NUM_REGS = 2**GPR_SIZE;
  localparam int RUN_W    = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_STALL);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_STALL - 1);
  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [3:0]          flush_cnt, flush_cnt_next;
  logic [NUM_REGS-1:0] pending;
  logic [RUN_W-1:0]    run_cnt;

  logic                hazard;
  logic                stall_int;
  logic                fire_int;
  logic                flush_int;
  logic                ld_hit;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // Uses registered scoreboard bits only; a load completing this cycle
  // releases its dependant on the following cycle.
  assign hazard = issue_valid &
                  ((issue_uses0  & pending[issue_address0]) |
                   (issue_uses1  & pending[issue_address1]) |
                   (issue_writes & pending[issue_destination]));

  // Next-state and outputs. Outputs are held low while reset is asserted.
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    flush_int      = 1'b0;
    stall_int      = 1'b0;
    fire_int       = 1'b0;

    case (state)
      ST_RUN: begin
        if (branch_taken) begin
          // Branch wins over a hazard stall: the stalled instruction is
          // on the wrong path and gets flushed anyway.
          state_next     = ST_FLUSH;
          flush_cnt_next = FLUSH_LOAD;
          flush_int      = 1'b1;
        end else begin
          stall_int = hazard;
          fire_int  = issue_valid & ~hazard;
        end
      end
      ST_FLUSH: begin
        flush_int = 1'b1;
        if (branch_taken) begin
          flush_cnt_next = FLUSH_LOAD;
        end else if (flush_cnt <= 4'd1) begin
          state_next     = ST_RUN;
          flush_cnt_next = 4'd0;
        end else begin
          flush_cnt_next = flush_cnt - 4'd1;
        end
      end
      default: begin
        state_next     = ST_RUN;
        flush_cnt_next = 4'd0;
      end
    endcase
  end

  assign stall_read  = rst_n & stall_int;
  assign stall_fetch = rst_n & stall_int;
  assign bubble_exec = rst_n & stall_int;
  assign flush_fetch = rst_n & flush_int;
  assign flush_read  = rst_n & flush_int;
  assign issue_fire  = rst_n & fire_int;

  // Scoreboard masks. If a set and a clear ever target the same register,
  // the set is applied last and wins.
  assign ld_hit   = pending[load_destination];
  assign set_mask = (fire_int & issue_is_load & issue_writes)
                    ? (NUM_REGS'(1) << issue_destination) : '0;
  assign clr_mask = (load_done & ld_hit)
                    ? (NUM_REGS'(1) << load_destination) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      flush_cnt <= 4'd0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending          <= '0;
      scoreboard_error <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      if (load_done && !ld_hit) begin
        scoreboard_error <= 1'b1;
      end
    end
  end

  // Stall statistics. The run counter parks at MAX_STALL so it cannot wrap
  // during very long stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt       <= '0;
      stall_count   <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if (stall_int) begin
        if (run_cnt != RUN_MAX) begin
          run_cnt <= run_cnt + 1'b1;
        end
        if (run_cnt == RUN_LAST) begin
          stall_timeout <= 1'b1;
        end
        if (stall_count != {CNT_W{1'b1}}) begin
          stall_count <= stall_count + 1'b1;
        end
      end else begin
        run_cnt <= '0;
      end
    end
  end

  assign pending_mask = pending;

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

  localparam int GPR_SIZE = 3;
  localparam int NUM_REGS = 8;
  localparam int CNT_W    = 16;

  logic                clk;
  logic                rst_n;
  logic                issue_valid;
  logic [GPR_SIZE-1:0] issue_address0;
  logic                issue_uses0;
  logic [GPR_SIZE-1:0] issue_address1;
  logic                issue_uses1;
  logic                issue_writes;
  logic [GPR_SIZE-1:0] issue_destination;
  logic                issue_is_load;
  logic                load_done;
  logic [GPR_SIZE-1:0] load_destination;
  logic                branch_taken;
  logic                stall_fetch;
  logic                stall_read;
  logic                bubble_exec;
  logic                flush_fetch;
  logic                flush_read;
  logic                issue_fire;
  logic [NUM_REGS-1:0] pending_mask;
  logic [CNT_W-1:0]    stall_count;
  logic                stall_timeout;
  logic                scoreboard_error;

  logic [31:0] exp_q[$];
  int n_asserts = 0;
  int n_fail    = 0;

  hazard_controller #(
    .GPR_SIZE(GPR_SIZE), .FLUSH_CYCLES(2), .MAX_STALL(64), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid),
    .issue_address0(issue_address0), .issue_uses0(issue_uses0),
    .issue_address1(issue_address1), .issue_uses1(issue_uses1),
    .issue_writes(issue_writes), .issue_destination(issue_destination),
    .issue_is_load(issue_is_load),
    .load_done(load_done), .load_destination(load_destination),
    .branch_taken(branch_taken),
    .stall_fetch(stall_fetch), .stall_read(stall_read),
    .bubble_exec(bubble_exec),
    .flush_fetch(flush_fetch), .flush_read(flush_read),
    .issue_fire(issue_fire), .pending_mask(pending_mask),
    .stall_count(stall_count), .stall_timeout(stall_timeout),
    .scoreboard_error(scoreboard_error)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle();
    issue_valid = 0; issue_address0 = 0; issue_uses0 = 0;
    issue_address1 = 0; issue_uses1 = 0; issue_writes = 0;
    issue_destination = 0; issue_is_load = 0;
    load_done = 0; load_destination = 0; branch_taken = 0;
  endtask

  task automatic drive_load(input logic [GPR_SIZE-1:0] dst);
    idle();
    issue_valid = 1; issue_writes = 1; issue_destination = dst; issue_is_load = 1;
  endtask

  task automatic drive_read0(input logic [GPR_SIZE-1:0] src);
    idle();
    issue_valid = 1; issue_uses0 = 1; issue_address0 = src;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard: expectation is queued, then popped against the DUT output
  task automatic expect_val(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_asserts++;
      n_fail++;
      $error("FAIL %s: no expectation queued, observed %0h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      n_asserts++;
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic ec(input string tag, input logic [31:0] obs, input logic [31:0] e);
    expect_val(e);
    chk(tag, obs);
  endtask

  task automatic chk_stall(input string tag, input logic s);
    ec({tag, "_stall_read"},  32'(stall_read),  32'(s));
    ec({tag, "_stall_fetch"}, 32'(stall_fetch), 32'(s));
    ec({tag, "_bubble_exec"}, 32'(bubble_exec), 32'(s));
  endtask

  task automatic chk_flush(input string tag, input logic f);
    ec({tag, "_flush_fetch"}, 32'(flush_fetch), 32'(f));
    ec({tag, "_flush_read"},  32'(flush_read),  32'(f));
  endtask

  initial begin
    // Reset with active inputs: all outputs must be zero
    rst_n = 0;
    idle();
    issue_valid = 1; branch_taken = 1;
    smp();
    chk_stall("rst", 1'b0);
    chk_flush("rst", 1'b0);
    ec("rst_fire", 32'(issue_fire), 0);
    ec("rst_pending", 32'(pending_mask), 0);
    ec("rst_stall_count", 32'(stall_count), 0);
    ec("rst_timeout", 32'(stall_timeout), 0);
    ec("rst_sb_err", 32'(scoreboard_error), 0);
    nxt(); rst_n = 1; idle();
    smp();
    chk_flush("idle", 1'b0);

    // Load r3, dependant stalls until the cycle after load_done
    nxt(); drive_load(3);
    smp();
    ec("ld3_fire", 32'(issue_fire), 1);
    chk_stall("ld3", 1'b0);
    ec("ld3_pending_pre", 32'(pending_mask), 0);
    nxt(); drive_read0(3); issue_writes = 1; issue_destination = 4;
    smp();
    ec("rd3_pending", 32'(pending_mask), 32'h08);
    chk_stall("rd3_a", 1'b1);
    ec("rd3_fire_a", 32'(issue_fire), 0);
    nxt();
    smp();
    chk_stall("rd3_b", 1'b1);
    ec("rd3_count_b", 32'(stall_count), 1);
    nxt(); load_done = 1; load_destination = 3;
    smp();
    chk_stall("rd3_nobypass", 1'b1);
    ec("rd3_fire_k", 32'(issue_fire), 0);
    ec("rd3_count_k", 32'(stall_count), 2);
    nxt(); load_done = 0;
    smp();
    chk_stall("rd3_k1", 1'b0);
    ec("rd3_fire_k1", 32'(issue_fire), 1);
    ec("rd3_pending_k1", 32'(pending_mask), 0);
    ec("rd3_count_k1", 32'(stall_count), 3);

    // Load r2; unused operand 1 pointing at r2 must not stall
    nxt(); drive_load(2);
    smp();
    ec("ld2_fire", 32'(issue_fire), 1);
    nxt(); drive_read0(5); issue_uses1 = 0; issue_address1 = 2;
    smp();
    ec("rd5_pending", 32'(pending_mask), 32'h04);
    chk_stall("rd5", 1'b0);
    ec("rd5_fire", 32'(issue_fire), 1);
    // WAW on r2 stalls
    nxt(); idle(); issue_valid = 1; issue_writes = 1; issue_destination = 2;
    smp();
    chk_stall("waw2", 1'b1);
    ec("waw2_fire", 32'(issue_fire), 0);
    nxt(); idle(); load_done = 1; load_destination = 2;
    smp();
    ec("ld2done_count", 32'(stall_count), 4);
    nxt(); idle();
    smp();
    ec("ld2done_pending", 32'(pending_mask), 0);

    // Branch during a hazard stall
    nxt(); drive_load(3);
    smp();
    ec("ld3b_fire", 32'(issue_fire), 1);
    nxt(); drive_read0(3);
    smp();
    chk_stall("br_pre", 1'b1);
    nxt(); branch_taken = 1;
    smp();
    chk_stall("br0", 1'b0);
    chk_flush("br0", 1'b1);
    ec("br0_fire", 32'(issue_fire), 0);
    ec("br0_count", 32'(stall_count), 5);
    nxt(); idle();
    smp();
    chk_flush("br1", 1'b1);
    nxt();
    smp();
    chk_flush("br2", 1'b1);
    nxt();
    smp();
    chk_flush("br3", 1'b0);
    ec("br3_pending", 32'(pending_mask), 32'h08);
    ec("br3_count", 32'(stall_count), 5);

    // Second branch inside FLUSH extends the flush
    nxt(); idle(); issue_valid = 1;
    smp();
    ec("nop_fire", 32'(issue_fire), 1);
    nxt(); branch_taken = 1;
    smp();
    chk_flush("bb0", 1'b1);
    ec("bb0_fire", 32'(issue_fire), 0);
    nxt(); branch_taken = 1;
    smp();
    chk_flush("bb1", 1'b1);
    ec("bb1_fire", 32'(issue_fire), 0);
    nxt(); branch_taken = 0;
    smp();
    chk_flush("bb2", 1'b1);
    ec("bb2_fire", 32'(issue_fire), 0);
    nxt();
    smp();
    chk_flush("bb3", 1'b1);
    ec("bb3_fire", 32'(issue_fire), 0);
    nxt();
    smp();
    chk_flush("bb4", 1'b0);
    ec("bb4_fire", 32'(issue_fire), 1);

    // Spurious load_done
    nxt(); idle(); load_done = 1; load_destination = 3;
    nxt(); idle(); load_done = 1; load_destination = 6;
    smp();
    ec("err_pending_pre", 32'(pending_mask), 0);
    ec("err_pre", 32'(scoreboard_error), 0);
    nxt(); idle();
    smp();
    ec("err_set", 32'(scoreboard_error), 1);
    ec("err_pending", 32'(pending_mask), 0);
    nxt();
    smp();
    ec("err_sticky", 32'(scoreboard_error), 1);

    // Reset mid-stall with r1 pending
    nxt(); drive_load(1);
    smp();
    ec("ld1_fire", 32'(issue_fire), 1);
    nxt(); drive_read0(1);
    smp();
    chk_stall("rs_pre", 1'b1);
    nxt(); rst_n = 0;
    #1;
    chk_stall("rs_low", 1'b0);
    ec("rs_low_fire", 32'(issue_fire), 0);
    ec("rs_low_pending", 32'(pending_mask), 0);
    ec("rs_low_count", 32'(stall_count), 0);
    nxt(); rst_n = 1;
    smp();
    ec("rs_pending", 32'(pending_mask), 0);
    ec("rs_count", 32'(stall_count), 0);
    ec("rs_sb_err", 32'(scoreboard_error), 0);
    chk_stall("rs_after", 1'b0);
    ec("rs_fire", 32'(issue_fire), 1);

    // Stall held 64 cycles sets the timeout
    nxt(); drive_load(1);
    smp();
    ec("to_ld_fire", 32'(issue_fire), 1);
    nxt(); drive_read0(1);
    for (int i = 0; i < 64; i++) begin
      smp();
      if (i == 0 || i == 63) begin
        ec("to_stall", 32'(stall_read), 1);
        ec("to_before", 32'(stall_timeout), 0);
      end
      nxt();
    end
    idle(); load_done = 1; load_destination = 1;
    smp();
    ec("to_set", 32'(stall_timeout), 1);
    ec("to_count", 32'(stall_count), 64);
    chk_stall("to_release", 1'b0);
    nxt(); idle();
    smp();
    ec("to_pending", 32'(pending_mask), 0);
    ec("to_sticky", 32'(stall_timeout), 1);
    ec("to_count_hold", 32'(stall_count), 64);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
